vector_accumulate_unit: RTL
===========================

Name: vector_accumulate_unit

Overview:
- Stage directly downstream of filterReduceUnit.
- Accumulates the per-cycle reduced vectors (histogram counts, sums) across a frame, independently for each chain.
- Emits one accumulated vector per frame on the selected end-of-frame marker; the emitted vector feeds the scalar-reduce and packing stages.
- Per-chain firmware selects passthrough, saturating sum or element-wise max, and is loaded over the shared configId/configData bus.

Parameters:
- N, 8, vector lanes.
- DATA_WIDTH, 32, bits per lane; all values are unsigned.
- MAX_CHAINS, 4, number of independent chains and accumulator slots.
- PERSONAL_CONFIG_ID, 1, configId value that addresses this block.
- INITIAL_FIRMWARE_OP, all 0, per-chain op: 0=passthrough, 1=sum, 2=max; any other value is treated as passthrough.
- INITIAL_FIRMWARE_EMIT, all 0, per-chain emit level: 0 = emit on eof_in[0], 1 = emit on eof_in[1].

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- tracing  in  1  1 = process data; 0 = reconfiguration mode.
- valid_in  in  1  input vector valid.
- eof_in  in  2  end-of-frame markers, bit0 = frame, bit1 = outer frame.
- bof_in  in  2  beginning-of-frame markers, same bit meaning.
- chainId_in  in  clog2(MAX_CHAINS)  chain of the input vector.
- configId  in  8  configuration target.
- configData  in  8  configuration byte.
- vector_in  in  N x DATA_WIDTH  input lanes.
- vector_out  out  N x DATA_WIDTH  output lanes.
- chainId_out  out  clog2(MAX_CHAINS)  chain of the output.
- valid_out  out  1  output valid.
- eof_out  out  2  registered copy of eof_in.
- bof_out  out  2  registered copy of bof_in.

Behaviour:
- Reset (asynchronous):
  - All outputs go to 0.
  - All accumulator lanes go to 0.
  - byte_counter goes to 0.
  - Firmware tables reload the INITIAL_* values.
  - A frame in progress is discarded; the next vector is summed onto zero unless it carries bof.
- Latency is 1 cycle, fully pipelined, no backpressure. eof_out, bof_out and chainId_out always follow their inputs by 1 cycle.
- Variables used below: c = chainId_in; e = eof_in[emit[c]]; b = bof_in[emit[c]].
- op 0 (passthrough): vector_out = vector_in and valid_out = valid_in. The accumulator is untouched.
- op 1 (sum), when valid_in=1:
  - new = b ? vector_in : sat(acc[c] + vector_in), per lane.
  - sat clamps at 2^DATA_WIDTH-1.
  - acc[c] <= new.
- op 2 (max), when valid_in=1:
  - new = b ? vector_in : max(acc[c], vector_in), per lane, unsigned compare.
  - acc[c] <= new.
- Emit for ops 1 and 2:
  - If e=1: vector_out = new and valid_out = 1.
  - Otherwise valid_out = 0 and vector_out holds its previous value.
- Simultaneous b=1 and e=1 is a single-vector frame: vector_out = vector_in and acc[c] = vector_in.
- valid_in=0: the accumulator is unchanged and valid_out = 0, even if eof is asserted.
- Chains are fully independent; interleaving chain IDs must not corrupt another chain's accumulator.
- Reconfiguration (tracing=0):
  - valid_out = 0; valid_in is ignored and accumulators are held.
  - When configId == PERSONAL_CONFIG_ID, each cycle writes configData, then byte_counter increments:
    - bytes 0..MAX_CHAINS-1 go to op[chain k];
    - bytes MAX_CHAINS..2*MAX_CHAINS-1 go to emit[chain k];
    - further bytes are ignored and the counter saturates at 255.
  - When configId differs, byte_counter <= 0.
- A tracing 1->0 transition mid-frame keeps the partial accumulation. The frame resumes when tracing returns to 1.

Test Plan:
- Sum accumulation: chain 0, op=1. Three valid vectors, all lanes = 2, 3, 5. bof on the first, eof[0] on the third. Expect a single valid_out, 1 cycle after the third input, with all lanes = 10; valid_out=0 on the other cycles.
- Saturation and max:
  - DATA_WIDTH=8, op=1, inputs 200 then 100 with eof. Expect lanes = 255.
  - op=2, lane0 inputs 7, 3, 9 with eof on the third. Expect lane0 = 9.
- Interleaved chains: alternate chain 0 (all lanes 1) and chain 1 (all lanes 4), 4 vectors each, bof first and eof last. Expect chain 0 output = 4 and chain 1 output = 16, with chainId_out correct on each.
- Config and edge cases:
  - tracing=0 and configId=PERSONAL_CONFIG_ID; send bytes 1,2,0,0,1,0,0,0. Expect chain 0 sum at emit level eof[1]; chain 1 max at emit level eof[0].
  - Then an eof[0]-only frame on chain 0 produces no output.
  - A bof+eof single vector of 6 on chain 1 outputs 6 immediately.
- Reset mid-frame: op=1, accumulate 5 and 5, assert reset for 1 cycle, then send 3 with eof and no bof. Expect output 3, and all outputs 0 while reset is high.
- Passthrough: op=0. A valid vector 0xA5 with valid_in toggling is reproduced 1 cycle later on vector_out and valid_out; eof_out and bof_out mirror the inputs with 1-cycle delay.

Source files
------------

// File: rtl/vector_accumulate_unit.sv
// Per-chain frame accumulator placed after filterReduceUnit: passthrough, saturating
// sum or element-wise max, emitting one vector per frame on the selected eof level.
module vector_accumulate_unit #(
  parameter int unsigned N                                    = 8,
  parameter int unsigned DATA_WIDTH                           = 32,
  parameter int unsigned MAX_CHAINS                           = 4,
  parameter logic [7:0]  PERSONAL_CONFIG_ID                   = 8'd1,
  parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_FIRMWARE_OP   = '0,
  parameter logic [MAX_CHAINS-1:0]      INITIAL_FIRMWARE_EMIT = '0,
  localparam int unsigned CHAIN_W = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             tracing,
  input  logic                             valid_in,
  input  logic [1:0]                       eof_in,
  input  logic [1:0]                       bof_in,
  input  logic [CHAIN_W-1:0]               chainId_in,
  input  logic [7:0]                       configId,
  input  logic [7:0]                       configData,
  input  logic [N-1:0][DATA_WIDTH-1:0]     vector_in,
  output logic [N-1:0][DATA_WIDTH-1:0]     vector_out,
  output logic [CHAIN_W-1:0]               chainId_out,
  output logic                             valid_out,
  output logic [1:0]                       eof_out,
  output logic [1:0]                       bof_out
);

  localparam logic [7:0] OP_SUM  = 8'd1;
  localparam logic [7:0] OP_MAX  = 8'd2;
  localparam logic [7:0] CNT_MAX = 8'hFF;

  logic [MAX_CHAINS-1:0][N-1:0][DATA_WIDTH-1:0] acc_q, acc_d;
  logic [MAX_CHAINS-1:0][7:0]                   op_q, op_d;
  logic [MAX_CHAINS-1:0]                        emit_q, emit_d;
  logic [7:0]                                   cnt_q, cnt_d;
  logic [N-1:0][DATA_WIDTH-1:0]                 vec_q, vec_d;
  logic                                         valid_q, valid_d;
  logic [1:0]                                   eof_q, bof_q;
  logic [CHAIN_W-1:0]                           chain_q;

  logic [7:0]                                   cur_op_c;
  logic                                         cur_emit_c;
  logic                                         e_c, b_c;
  logic [N-1:0][DATA_WIDTH-1:0]                 acc_cur_c;
  logic [N-1:0][DATA_WIDTH:0]                   lane_sum_c;
  logic [N-1:0][DATA_WIDTH-1:0]                 new_c;

  // Per-lane candidate value for the addressed chain; bof restarts from the input.
  always_comb begin
    cur_op_c   = op_q[chainId_in];
    cur_emit_c = emit_q[chainId_in];
    e_c        = eof_in[cur_emit_c];
    b_c        = bof_in[cur_emit_c];
    acc_cur_c  = acc_q[chainId_in];
    lane_sum_c = '0;
    new_c      = '0;
    for (int l = 0; l < int'(N); l++) begin
      lane_sum_c[l] = {1'b0, acc_cur_c[l]} + {1'b0, vector_in[l]};
      if (b_c) begin
        new_c[l] = vector_in[l];
      end else if (cur_op_c == OP_MAX) begin
        new_c[l] = (acc_cur_c[l] >= vector_in[l]) ? acc_cur_c[l] : vector_in[l];
      end else begin
        new_c[l] = lane_sum_c[l][DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : lane_sum_c[l][DATA_WIDTH-1:0];
      end
    end
  end

  // Next-state: tracing datapath or firmware byte loading.
  always_comb begin
    acc_d   = acc_q;
    op_d    = op_q;
    emit_d  = emit_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    valid_d = 1'b0;

    if (tracing) begin
      if (cur_op_c == OP_SUM || cur_op_c == OP_MAX) begin
        if (valid_in) begin
          acc_d[chainId_in] = new_c;
          if (e_c) begin
            vec_d   = new_c;
            valid_d = 1'b1;
          end
        end
      end else begin
        vec_d   = vector_in;
        valid_d = valid_in;
      end
    end else if (configId == PERSONAL_CONFIG_ID) begin
      for (int k = 0; k < int'(MAX_CHAINS); k++) begin
        if (cnt_q == 8'(k))              op_d[k]   = configData;
        if (cnt_q == 8'(MAX_CHAINS + k)) emit_d[k] = configData[0];
      end
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 8'd1;
    end

    if (configId != PERSONAL_CONFIG_ID) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      op_q    <= INITIAL_FIRMWARE_OP;
      emit_q  <= INITIAL_FIRMWARE_EMIT;
      cnt_q   <= '0;
      vec_q   <= '0;
      valid_q <= 1'b0;
      eof_q   <= '0;
      bof_q   <= '0;
      chain_q <= '0;
    end else begin
      acc_q   <= acc_d;
      op_q    <= op_d;
      emit_q  <= emit_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      valid_q <= valid_d;
      eof_q   <= eof_in;
      bof_q   <= bof_in;
      chain_q <= chainId_in;
    end
  end

  assign vector_out  = vec_q;
  assign valid_out   = valid_q;
  assign eof_out     = eof_q;
  assign bof_out     = bof_q;
  assign chainId_out = chain_q;

endmodule
